// File: rtl/cpr_pkg.sv
// Shared CPR definitions: sequencer state type and default timing constants,
// also used by the drug-delivery block.
package cpr_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPRESS  = 2'd1,
        VENTILATE = 2'd2,
        REASSESS  = 2'd3
    } cpr_state_t;

    localparam int DEF_CLK_PER_COMP    = 10;
    localparam int DEF_COMP_ON_CYCLES  = 5;
    localparam int DEF_COMPS_PER_SET   = 30;
    localparam int DEF_CLK_PER_BREATH  = 20;
    localparam int DEF_BREATHS_PER_SET = 2;
    localparam int DEF_SETS_PER_ROUND  = 5;
    localparam int DEF_REASSESS_CYCLES = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int PCNT_W = $clog2(max3(DEF_CLK_PER_COMP, DEF_CLK_PER_BREATH,
                                        DEF_REASSESS_CYCLES));

endpackage

// File: rtl/cpr_compression_sequencer_timer.sv
// Shared period counter: counts 0..last_i and wraps, flags the terminal count
// and whether the count is still inside the "on" part of the period.
module cpr_period_timer
    import cpr_pkg::*;
#(
    parameter int W = PCNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] last_i,
    input  logic [W-1:0] thresh_i,
    output logic         tc_o,
    output logic         on_phase_o
);

    logic [W-1:0] pcnt_q;
    logic [W-1:0] pcnt_d;

    assign tc_o       = (pcnt_q == last_i);
    assign on_phase_o = (pcnt_q < thresh_i);

    always_comb begin
        pcnt_d = pcnt_q + W'(1);
        if (load_i || tc_o) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/cpr_compression_sequencer.sv
// Mechanical CPR sequencer: 30:2 compression/ventilation sets, a reassessment
// hold after each round, and graceful abort at the end of the running period.
module cpr_compression_sequencer
    import cpr_pkg::*;
#(
    parameter int CLK_PER_COMP    = DEF_CLK_PER_COMP,
    parameter int COMP_ON_CYCLES  = DEF_COMP_ON_CYCLES,
    parameter int COMPS_PER_SET   = DEF_COMPS_PER_SET,
    parameter int CLK_PER_BREATH  = DEF_CLK_PER_BREATH,
    parameter int BREATHS_PER_SET = DEF_BREATHS_PER_SET,
    parameter int SETS_PER_ROUND  = DEF_SETS_PER_ROUND,
    parameter int REASSESS_CYCLES = DEF_REASSESS_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpr_activate,
    output logic       compression_out,
    output logic       ventilation_out,
    output logic [5:0] comp_count,
    output logic [3:0] set_count,
    output logic       busy,
    output logic       reassess_pulse
);

    localparam int PW = $clog2(max3(CLK_PER_COMP, CLK_PER_BREATH, REASSESS_CYCLES));

    cpr_state_t state_q, state_d;
    logic [5:0] comp_count_q, comp_count_d;
    logic [3:0] set_count_q, set_count_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic       abort_q, abort_d;
    logic       comp_out_q, vent_out_q, busy_q, pulse_q;

    logic [PW-1:0] last;
    logic [PW-1:0] thresh;
    logic          tc;
    logic          on_phase;
    logic          abort_now;

    cpr_period_timer #(.W(PW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == IDLE),
        .last_i     (last),
        .thresh_i   (thresh),
        .tc_o       (tc),
        .on_phase_o (on_phase)
    );

    // A drop of cpr_activate counts immediately, so a drop on the wrap cycle ends the run too.
    assign abort_now = abort_q | ~cpr_activate;

    always_comb begin
        state_d      = state_q;
        comp_count_d = comp_count_q;
        set_count_d  = set_count_q;
        bcnt_d       = bcnt_q;
        abort_d      = abort_q;
        last         = '0;
        thresh       = '0;
        unique case (state_q)
            IDLE: begin
                if (cpr_activate) begin
                    state_d = COMPRESS;
                end
            end
            COMPRESS: begin
                last    = PW'(CLK_PER_COMP - 1);
                thresh  = PW'(COMP_ON_CYCLES);
                abort_d = abort_now;
                if (tc) begin
                    if (abort_now) begin
                        state_d      = IDLE;
                        comp_count_d = '0;
                        set_count_d  = '0;
                        bcnt_d       = '0;
                        abort_d      = 1'b0;
                    end else if (comp_count_q == 6'(COMPS_PER_SET - 1)) begin
                        comp_count_d = '0;
                        state_d      = VENTILATE;
                    end else begin
                        comp_count_d = comp_count_q + 6'd1;
                    end
                end
            end
            VENTILATE: begin
                last    = PW'(CLK_PER_BREATH - 1);
                thresh  = PW'(CLK_PER_BREATH / 2);
                abort_d = abort_now;
                if (tc) begin
                    if (abort_now) begin
                        state_d      = IDLE;
                        comp_count_d = '0;
                        set_count_d  = '0;
                        bcnt_d       = '0;
                        abort_d      = 1'b0;
                    end else if (bcnt_q == 3'(BREATHS_PER_SET - 1)) begin
                        bcnt_d      = '0;
                        set_count_d = set_count_q + 4'd1;
                        state_d     = (set_count_q == 4'(SETS_PER_ROUND - 1)) ? REASSESS : COMPRESS;
                    end else begin
                        bcnt_d = bcnt_q + 3'd1;
                    end
                end
            end
            REASSESS: begin
                last = PW'(REASSESS_CYCLES - 1);
                if (tc) begin
                    set_count_d = '0;
                    state_d     = cpr_activate ? COMPRESS : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            comp_count_q <= '0;
            set_count_q  <= '0;
            bcnt_q       <= '0;
            abort_q      <= 1'b0;
            comp_out_q   <= 1'b0;
            vent_out_q   <= 1'b0;
            busy_q       <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            comp_count_q <= comp_count_d;
            set_count_q  <= set_count_d;
            bcnt_q       <= bcnt_d;
            abort_q      <= abort_d;
            comp_out_q   <= (state_q == COMPRESS) && on_phase;
            vent_out_q   <= (state_q == VENTILATE) && on_phase;
            busy_q       <= (state_d != IDLE);
            pulse_q      <= (state_d == REASSESS) && (state_q != REASSESS);
        end
    end

    assign compression_out = comp_out_q;
    assign ventilation_out = vent_out_q;
    assign comp_count      = comp_count_q;
    assign set_count       = set_count_q;
    assign busy            = busy_q;
    assign reassess_pulse  = pulse_q;

endmodule

// File: tb/tb_cpr_compression_sequencer.sv
// Bench for the CPR sequencer: a time-within-round model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cpr_compression_sequencer;

    localparam int CPC      = 10;
    localparam int ON       = 5;
    localparam int CPS      = 30;
    localparam int CPB      = 20;
    localparam int BPS      = 2;
    localparam int SPR      = 5;
    localparam int RC       = 16;
    localparam int COMP_LEN = CPS * CPC;
    localparam int SET_LEN  = COMP_LEN + BPS * CPB;
    localparam int ACT_LEN  = SPR * SET_LEN;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpr_activate = 1'b0;
    logic       compression_out;
    logic       ventilation_out;
    logic [5:0] comp_count;
    logic [3:0] set_count;
    logic       busy;
    logic       reassess_pulse;

    cpr_compression_sequencer #(
        .CLK_PER_COMP    (CPC),
        .COMP_ON_CYCLES  (ON),
        .COMPS_PER_SET   (CPS),
        .CLK_PER_BREATH  (CPB),
        .BREATHS_PER_SET (BPS),
        .SETS_PER_ROUND  (SPR),
        .REASSESS_CYCLES (RC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cpr_activate    (cpr_activate),
        .compression_out (compression_out),
        .ventilation_out (ventilation_out),
        .comp_count      (comp_count),
        .set_count       (set_count),
        .busy            (busy),
        .reassess_pulse  (reassess_pulse)
    );

    always #5 clk = ~clk;

    // Model: position in the round is just elapsed cycles since the round began.
    int m_t = 0;
    bit m_run = 1'b0;
    bit m_abort = 1'b0;
    bit valid = 1'b0;
    bit exp_comp = 1'b0, exp_vent = 1'b0, exp_busy = 1'b0, exp_pulse = 1'b0;
    int exp_cc = 0, exp_sc = 0;

    // ph: 0 compressing, 1 ventilating, 2 reassessing
    function automatic void decode(input int t, output int ph, output int pos,
                                   output int cc, output int sc);
        int r;
        if (t >= ACT_LEN) begin
            ph = 2; pos = t - ACT_LEN; cc = 0; sc = SPR;
        end else begin
            sc = t / SET_LEN;
            r  = t % SET_LEN;
            if (r < COMP_LEN) begin
                ph = 0; pos = r % CPC; cc = r / CPC;
            end else begin
                ph = 1; pos = (r - COMP_LEN) % CPB; cc = 0;
            end
        end
    endfunction

    always @(posedge clk) begin : model
        int ph, pos, cc, sc, n_t;
        bit n_run, n_abort, wrap;
        decode(m_t, ph, pos, cc, sc);
        n_t = m_t; n_run = m_run; n_abort = m_abort;
        if (rst) begin
            n_run = 1'b0; n_t = 0; n_abort = 1'b0;
        end else if (!m_run) begin
            if (cpr_activate) begin
                n_run = 1'b1; n_t = 0;
            end
        end else begin
            wrap = (ph == 0 && pos == CPC - 1) || (ph == 1 && pos == CPB - 1) ||
                   (ph == 2 && pos == RC - 1);
            if (ph != 2 && !cpr_activate) n_abort = 1'b1;
            if (wrap && ph != 2 && n_abort) begin
                n_run = 1'b0; n_t = 0; n_abort = 1'b0;
            end else if (wrap && ph == 2) begin
                n_t = 0; n_run = cpr_activate;
            end else begin
                n_t = m_t + 1;
            end
        end
        exp_comp <= !rst && m_run && ph == 0 && pos < ON;
        exp_vent <= !rst && m_run && ph == 1 && pos < CPB / 2;
        decode(n_t, ph, pos, cc, sc);
        m_t       <= n_t;
        m_run     <= n_run;
        m_abort   <= n_abort;
        exp_busy  <= n_run;
        exp_cc    <= n_run ? cc : 0;
        exp_sc    <= n_run ? sc : 0;
        exp_pulse <= n_run && ph == 2 && pos == 0;
        valid     <= valid | rst;
    end

    int checks = 0;
    int errors = 0;
    int comp_hi = 0, vent_hi = 0, comp_rise = 0, vent_rise = 0, pulse_n = 0;
    bit prev_comp = 1'b0, prev_vent = 1'b0;
    int s_comp_hi, s_vent_hi, s_comp_rise, s_vent_rise, s_pulse;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (compression_out) comp_hi++;
            if (ventilation_out) vent_hi++;
            if (compression_out && !prev_comp) comp_rise++;
            if (ventilation_out && !prev_vent) vent_rise++;
            if (reassess_pulse) pulse_n++;
            prev_comp = compression_out;
            prev_vent = ventilation_out;
            if (valid) begin
                check("compression_out", int'(compression_out), int'(exp_comp));
                check("ventilation_out", int'(ventilation_out), int'(exp_vent));
                check("busy", int'(busy), int'(exp_busy));
                check("comp_count", int'(comp_count), exp_cc);
                check("set_count", int'(set_count), exp_sc);
                check("reassess_pulse", int'(reassess_pulse), int'(exp_pulse));
                check("strobe_exclusive", int'(compression_out && ventilation_out), 0);
            end
        end
    endtask

    task automatic snap();
        s_comp_hi = comp_hi; s_vent_hi = vent_hi;
        s_comp_rise = comp_rise; s_vent_rise = vent_rise; s_pulse = pulse_n;
    endtask

    initial begin
        $display("txn: reset and start");
        rst = 1'b1; cpr_activate = 1'b0;
        tick(3);
        check("reset_busy", int'(busy), 0);
        check("reset_comp", int'(compression_out), 0);
        check("reset_set", int'(set_count), 0);
        rst = 1'b0; cpr_activate = 1'b1;
        snap();
        tick(1);
        check("start_busy", int'(busy), 1);
        check("start_latency", int'(compression_out), 0);
        tick(1);
        check("first_stroke", int'(compression_out), 1);

        $display("txn: full set");
        tick(339);
        check("set1_set_count", int'(set_count), 1);
        check("set1_comp_pulses", comp_rise - s_comp_rise, 30);
        check("set1_vent_pulses", vent_rise - s_vent_rise, 2);
        check("set1_vent_cycles", vent_hi - s_vent_hi, 20);
        check("set1_gap", int'(compression_out), 0);
        tick(1);
        check("set1_resume", int'(compression_out), 1);

        $display("txn: round with reassess, resume");
        snap();
        tick(ACT_LEN - 341);
        check("round_pulse", int'(reassess_pulse), 1);
        check("round_set_count", int'(set_count), 5);
        s_comp_hi = comp_hi; s_vent_hi = vent_hi;
        tick(RC);
        check("reassess_quiet", (comp_hi - s_comp_hi) + (vent_hi - s_vent_hi), 0);
        check("reassess_pulse_once", pulse_n - s_pulse, 1);
        check("round2_set_count", int'(set_count), 0);
        check("round2_busy", int'(busy), 1);
        tick(1);
        check("round2_stroke", int'(compression_out), 1);

        $display("txn: round with reassess, stop");
        tick(ACT_LEN - 1);
        check("round2_pulse", int'(reassess_pulse), 1);
        cpr_activate = 1'b0;
        tick(RC - 1);
        check("reassess_busy", int'(busy), 1);
        tick(1);
        check("stop_busy", int'(busy), 0);
        check("stop_set_count", int'(set_count), 0);

        $display("txn: mid-stroke abort");
        cpr_activate = 1'b1;
        tick(111);
        check("abort_comp_count", int'(comp_count), 11);
        snap();
        tick(2);
        check("abort_stroke_on", int'(compression_out), 1);
        cpr_activate = 1'b0;
        tick(7);
        check("abort_still_busy", int'(busy), 1);
        tick(1);
        check("abort_idle", int'(busy), 0);
        check("abort_comp_clear", int'(comp_count), 0);
        check("abort_stroke_len", comp_hi - s_comp_hi, 5);
        tick(20);
        check("abort_no_vent", vent_hi - s_vent_hi, 0);

        $display("txn: abort at set end");
        cpr_activate = 1'b1;
        snap();
        tick(293);
        check("setend_comp_count", int'(comp_count), 29);
        cpr_activate = 1'b0;
        tick(3);
        cpr_activate = 1'b1;
        tick(5);
        check("setend_idle", int'(busy), 0);
        check("setend_set_count", int'(set_count), 0);
        cpr_activate = 1'b0;
        tick(20);
        check("setend_no_vent", vent_hi - s_vent_hi, 0);

        $display("txn: reset mid-ventilation");
        cpr_activate = 1'b1;
        tick(306);
        check("vent_on", int'(ventilation_out), 1);
        rst = 1'b1;
        tick(1);
        check("rst_vent", int'(ventilation_out), 0);
        check("rst_comp", int'(compression_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_comp_count", int'(comp_count), 0);
        rst = 1'b0; cpr_activate = 1'b0;
        tick(3);
        check("rst_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
